// File: rtl/if_id_fetch_stage_pkg.sv
// Shared constants for the MIPS fetch stage: IF/ID control encodings, nop word, reset PC.
package if_id_fetch_stage_pkg;

    typedef enum logic [1:0] {
        IF_ID_HOLD     = 2'b00,
        IF_ID_BUBBLE   = 2'b01,
        IF_ID_LOAD     = 2'b10,
        IF_ID_LOAD_ALT = 2'b11
    } if_id_ctrl_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_fetch_stage_pc_reg.sv
// Program counter flop: a taken-branch redirect beats the sequential-advance enable.
module if_id_fetch_stage_pc_reg #(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] target_i,
    input  logic [WIDTH-1:0] seq_i,
    output logic [WIDTH-1:0] pc_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_o <= RESET_PC;
        end else if (redirect_i) begin
            pc_o <= target_i;
        end else if (en_i) begin
            pc_o <= seq_i;
        end
    end

endmodule

// File: rtl/if_id_fetch_stage.sv
// Fetch stage of the 5-stage MIPS pipeline: PC, PC+4, branch redirect and the IF/ID register,
// steered by the hazard unit's pc_write / IF_ID_Write controls.
module if_id_fetch_stage
    import if_id_fetch_stage_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
    parameter int               CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pc_write_i,
    input  logic [1:0]       IF_ID_Write_i,
    input  logic             branch_taken_i,
    input  logic [WIDTH-1:0] branch_target_i,
    output logic [WIDTH-1:0] instr_addr_o,
    input  logic [WIDTH-1:0] instr_i,
    output logic [WIDTH-1:0] IF_ID_pc4_o,
    output logic [WIDTH-1:0] IF_ID_instr_o,
    output logic             IF_ID_valid_o,
    output logic [4:0]       IF_rs_o,
    output logic [4:0]       IF_rt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    if_id_ctrl_e      if_id_ctrl;
    logic [WIDTH-1:0] pc_p0;
    logic [WIDTH-1:0] pc4_p0;
    logic             load_p0;
    logic             bubble_p0;
    logic             stall_p0;
    logic [WIDTH-1:0] if_id_pc4_p1;
    logic [WIDTH-1:0] if_id_instr_p1;
    logic             vld_p1;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] fetch_cnt_q;

    // ---- IF (p0): PC, sequential address, control decode ----
    if_id_fetch_stage_pc_reg #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (pc_write_i),
        .redirect_i (branch_taken_i),
        .target_i   (branch_target_i),
        .seq_i      (pc4_p0),
        .pc_o       (pc_p0)
    );

    assign pc4_p0     = pc_p0 + WIDTH'(4);
    assign if_id_ctrl = if_id_ctrl_e'(IF_ID_Write_i);

    always_comb begin
        load_p0   = 1'b0;
        bubble_p0 = 1'b0;
        if (branch_taken_i) begin
            bubble_p0 = 1'b1;
        end else begin
            case (if_id_ctrl)
                IF_ID_BUBBLE:              bubble_p0 = 1'b1;
                IF_ID_LOAD, IF_ID_LOAD_ALT: load_p0   = 1'b1;
                default:                   ;
            endcase
        end
    end

    assign stall_p0 = !pc_write_i && !branch_taken_i;

    // ---- IF/ID register (p1) and performance counters ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_id_pc4_p1   <= '0;
            if_id_instr_p1 <= WIDTH'(NOP_INSTR);
            vld_p1         <= 1'b0;
            stall_cnt_q    <= '0;
            fetch_cnt_q    <= '0;
        end else begin
            if (bubble_p0) begin
                if_id_pc4_p1   <= '0;
                if_id_instr_p1 <= WIDTH'(NOP_INSTR);
                vld_p1         <= 1'b0;
            end else if (load_p0) begin
                if_id_pc4_p1   <= pc4_p0;
                if_id_instr_p1 <= instr_i;
                vld_p1         <= 1'b1;
            end
            if (stall_p0) stall_cnt_q <= sat_inc(stall_cnt_q);
            if (load_p0)  fetch_cnt_q <= sat_inc(fetch_cnt_q);
        end
    end

    assign instr_addr_o  = pc_p0;
    assign IF_ID_pc4_o   = if_id_pc4_p1;
    assign IF_ID_instr_o = if_id_instr_p1;
    assign IF_ID_valid_o = vld_p1;
    assign IF_rs_o       = if_id_instr_p1[25:21];
    assign IF_rt_o       = if_id_instr_p1[20:16];
    assign stall_cnt_o   = stall_cnt_q;
    assign fetch_cnt_o   = fetch_cnt_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Scoreboard bench for the fetch stage: a cycle model pushes expected state per driven cycle,
// popped and compared one clock later.
module tb_if_id_fetch_stage;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          pc_write_i;
    logic [1:0]    IF_ID_Write_i;
    logic          branch_taken_i;
    logic [W-1:0]  branch_target_i;
    logic [W-1:0]  instr_addr_o;
    logic [W-1:0]  instr_i;
    logic [W-1:0]  IF_ID_pc4_o;
    logic [W-1:0]  IF_ID_instr_o;
    logic          IF_ID_valid_o;
    logic [4:0]    IF_rs_o;
    logic [4:0]    IF_rt_o;
    logic [CW-1:0] stall_cnt_o;
    logic [CW-1:0] fetch_cnt_o;

    if_id_fetch_stage #(.WIDTH(W), .RESET_PC(32'h0), .CNT_W(CW)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .pc_write_i      (pc_write_i),
        .IF_ID_Write_i   (IF_ID_Write_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .instr_addr_o    (instr_addr_o),
        .instr_i         (instr_i),
        .IF_ID_pc4_o     (IF_ID_pc4_o),
        .IF_ID_instr_o   (IF_ID_instr_o),
        .IF_ID_valid_o   (IF_ID_valid_o),
        .IF_rs_o         (IF_rs_o),
        .IF_rt_o         (IF_rt_o),
        .stall_cnt_o     (stall_cnt_o),
        .fetch_cnt_o     (fetch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [W-1:0] imem(input logic [W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2108_0000;
    endfunction

    logic         ovr_en  = 1'b0;
    logic [W-1:0] ovr_val = '0;
    always_comb instr_i = ovr_en ? ovr_val : imem(instr_addr_o);

    typedef struct {
        logic [W-1:0]  pc;
        logic [W-1:0]  pc4;
        logic [W-1:0]  instr;
        logic          vld;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m.pc = '0; m.pc4 = '0; m.instr = '0; m.vld = 1'b0; m.sc = '0; m.fc = '0;
    endtask

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Drive one cycle of controls, predict the post-edge state, compare after the edge.
    task automatic step(input logic pcw, input logic [1:0] ifw, input logic br, input logic [W-1:0] tgt);
        exp_t         e;
        exp_t         got;
        logic [W-1:0] fetched;
        pc_write_i = pcw; IF_ID_Write_i = ifw; branch_taken_i = br; branch_target_i = tgt;
        fetched = ovr_en ? ovr_val : imem(m.pc);
        e = m;
        if (br)       e.pc = tgt;
        else if (pcw) e.pc = m.pc + 32'd4;
        if (br || ifw == 2'b01) begin
            e.instr = '0; e.pc4 = '0; e.vld = 1'b0;
        end else if (ifw[1]) begin
            e.instr = fetched; e.pc4 = m.pc + 32'd4; e.vld = 1'b1; e.fc = sat(m.fc);
        end
        if (!pcw && !br) e.sc = sat(m.sc);
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        got = sb.pop_front();
        chk("pc",    instr_addr_o,  got.pc);
        chk("pc4",   IF_ID_pc4_o,   got.pc4);
        chk("instr", IF_ID_instr_o, got.instr);
        chk("valid", {31'b0, IF_ID_valid_o}, {31'b0, got.vld});
        chk("rs",    {27'b0, IF_rs_o}, {27'b0, got.instr[25:21]});
        chk("rt",    {27'b0, IF_rt_o}, {27'b0, got.instr[20:16]});
        chk("stall_cnt", {28'b0, stall_cnt_o}, {28'b0, got.sc});
        chk("fetch_cnt", {28'b0, fetch_cnt_o}, {28'b0, got.fc});
        m = got;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},    instr_addr_o,  32'h0);
        chk({tag, "_pc4"},   IF_ID_pc4_o,   32'h0);
        chk({tag, "_instr"}, IF_ID_instr_o, 32'h0);
        chk({tag, "_valid"}, {31'b0, IF_ID_valid_o}, 32'h0);
        chk({tag, "_scnt"},  {28'b0, stall_cnt_o},    32'h0);
        chk({tag, "_fcnt"},  {28'b0, fetch_cnt_o},    32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; pc_write_i = 1'b1; IF_ID_Write_i = 2'b10;
        branch_taken_i = 1'b0; branch_target_i = '0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset_vals("rst");
        rst_i = 1'b0;
        #1;
        chk("rel_pc", instr_addr_o, 32'h0);
        chk("rel_valid", {31'b0, IF_ID_valid_o}, 32'h0);

        step(1'b1, 2'b10, 1'b0, '0);
        chk("seq_pc4", instr_addr_o, 32'h4);
        step(1'b1, 2'b10, 1'b0, '0);
        chk("seq_pc8", instr_addr_o, 32'h8);

        // load-use stall at PC=8
        step(1'b0, 2'b00, 1'b0, '0);
        chk("stall_pc", instr_addr_o, 32'h8);
        chk("stall_instr", IF_ID_instr_o, imem(32'h4));
        step(1'b1, 2'b10, 1'b0, '0);
        chk("post_stall_pc", instr_addr_o, 32'hC);

        // branch during stall
        step(1'b0, 2'b00, 1'b1, 32'h40);
        chk("br_pc", instr_addr_o, 32'h40);
        chk("br_valid", {31'b0, IF_ID_valid_o}, 32'h0);

        // bubble then load of lw r2, 4(r1)
        ovr_en = 1'b1; ovr_val = 32'h8C22_0004;
        step(1'b1, 2'b01, 1'b0, '0);
        step(1'b1, 2'b10, 1'b0, '0);
        chk("lw_rs", {27'b0, IF_rs_o}, 32'd1);
        chk("lw_rt", {27'b0, IF_rt_o}, 32'd2);
        ovr_en = 1'b0;
        step(1'b1, 2'b11, 1'b0, '0);
        step(1'b1, 2'b00, 1'b0, '0);

        // PC wrap
        step(1'b0, 2'b00, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 2'b10, 1'b0, '0);
        chk("wrap_pc", instr_addr_o, 32'h0);
        chk("wrap_pc4", IF_ID_pc4_o, 32'h0);

        // drive both counters into saturation
        for (int i = 0; i < 18; i++) step(1'b0, 2'b10, 1'b0, '0);
        chk("stall_sat", {28'b0, stall_cnt_o}, 32'hF);
        chk("fetch_sat", {28'b0, fetch_cnt_o}, 32'hF);

        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), {$urandom} & 32'hFFFF_FFFC);

        // async reset mid-stall
        step(1'b0, 2'b00, 1'b0, '0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk_reset_vals("async");
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        step(1'b1, 2'b10, 1'b0, '0);
        chk("after_rst_instr", IF_ID_instr_o, imem(32'h0));
        chk("after_rst_pc", instr_addr_o, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
